// File: rtl/sphere3hopf_scheduler.sv
// rtl/sphere3hopf_scheduler.sv - round-robin scheduler sharing one sphere3hopf generator
// Every output is a flop loaded on the edge that leaves the state driving it.
module sphere3hopf_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_reseed,
   input  logic [32*NUM_REQ-1:0] req_seed,
   output logic [NUM_REQ-1:0]    grant,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [31:0]           rsp_x,
   output logic [31:0]           rsp_y,
   output logic [31:0]           rsp_z,
   output logic [31:0]           rsp_w,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  gen_pop_enable,
   output logic                  gen_reseed_enable,
   output logic [31:0]           gen_seed,
   input  logic [31:0]           gen_x,
   input  logic [31:0]           gen_y,
   input  logic [31:0]           gen_z,
   input  logic [31:0]           gen_w,
   input  logic                  gen_valid
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic                 rsp_err_q, rsp_err_d;
   logic                 busy_q, busy_d;
   logic                 pop_q, pop_d;
   logic                 reseed_q, reseed_d;
   logic [31:0]          seed_q, seed_d;
   logic [127:0]         coord_q, coord_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        last_q, last_d;
   logic [IW-1:0]        win_q, win_d;
   logic                 op_reseed_q, op_reseed_d;
   logic                 err_q, err_d;
   logic [IW:0]          pick;

   // Scan from the highest index offset down so the nearest requester after last_q wins.
   function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [IW-1:0] last);
      logic [IW:0] r;
      int          j;
      r = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         j = (int'(last) + k) % NUM_REQ;
         if (v[j]) r = {1'b1, IW'(j)};
      end
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      grant_d     = '0;
      rsp_valid_d = '0;
      rsp_err_d   = 1'b0;
      pop_d       = 1'b0;
      reseed_d    = 1'b0;
      seed_d      = seed_q;
      coord_d     = coord_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      win_d       = win_q;
      op_reseed_d = op_reseed_q;
      err_d       = err_q;
      pick        = rr_pick(req_valid, last_q);
      case (state_q)
         IDLE: begin
            if (pick[IW]) begin
               state_d     = ISSUE;
               grant_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick[IW-1:0];
               win_d       = pick[IW-1:0];
               last_d      = pick[IW-1:0];
               op_reseed_d = req_reseed[pick[IW-1:0]];
               seed_d      = req_seed[32*int'(pick[IW-1:0]) +: 32];
            end
         end
         ISSUE: begin
            if (op_reseed_q) begin
               reseed_d = 1'b1;
               coord_d  = '0;
               err_d    = 1'b0;
               state_d  = RESP;
            end else begin
               pop_d   = 1'b1;
               cnt_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // A valid arriving in the final counted cycle still beats the timeout.
            if (gen_valid) begin
               coord_d = {gen_x, gen_y, gen_z, gen_w};
               err_d   = 1'b0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q + CW'(1) == CW'(TIMEOUT)) begin
                  coord_d = '0;
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            rsp_valid_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_q;
            rsp_err_d   = err_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rsp_valid_q <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         pop_q       <= 1'b0;
         reseed_q    <= 1'b0;
         seed_q      <= '0;
         coord_q     <= '0;
         cnt_q       <= '0;
         last_q      <= IW'(NUM_REQ - 1);
         win_q       <= '0;
         op_reseed_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
         pop_q       <= pop_d;
         reseed_q    <= reseed_d;
         seed_q      <= seed_d;
         coord_q     <= coord_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         win_q       <= win_d;
         op_reseed_q <= op_reseed_d;
         err_q       <= err_d;
      end
   end

   assign grant             = grant_q;
   assign rsp_valid         = rsp_valid_q;
   assign rsp_err           = rsp_err_q;
   assign busy              = busy_q;
   assign gen_pop_enable    = pop_q;
   assign gen_reseed_enable = reseed_q;
   assign gen_seed          = seed_q;
   assign {rsp_x, rsp_y, rsp_z, rsp_w} = coord_q;

endmodule

// File: tb/tb_sphere3hopf_scheduler.sv
// tb/tb_sphere3hopf_scheduler.sv - table-driven bench for sphere3hopf_scheduler
module tb_sphere3hopf_scheduler;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   req_valid = '0;
   logic [3:0]   req_reseed = '0;
   logic [127:0] req_seed = '0;
   logic [3:0]   grant, rsp_valid;
   logic [31:0]  rsp_x, rsp_y, rsp_z, rsp_w, gen_seed;
   logic         rsp_err, busy, gen_pop_enable, gen_reseed_enable;
   logic [31:0]  gen_x = '0, gen_y = '0, gen_z = '0, gen_w = '0;
   logic         gen_valid = 1'b0;

   int errors = 0;
   int checks = 0;
   int cur_lat = -1;
   logic [127:0] cur_gen = '0;
   logic prev_rsp = 1'b0;

   typedef struct {
      logic [3:0]   mask;
      logic [3:0]   reseed;
      logic [31:0]  seed;
      int           lat;
      logic [127:0] gen;
      logic [3:0]   exp_grant;
      logic [127:0] exp_xyzw;
      logic         exp_err;
      int           exp_lat;
   } vec_t;

   vec_t vecs[15];
   vec_t hv;

   sphere3hopf_scheduler #(.NUM_REQ(4), .TIMEOUT(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_reseed(req_reseed), .req_seed(req_seed),
      .grant(grant), .rsp_valid(rsp_valid),
      .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z), .rsp_w(rsp_w),
      .rsp_err(rsp_err), .busy(busy),
      .gen_pop_enable(gen_pop_enable), .gen_reseed_enable(gen_reseed_enable),
      .gen_seed(gen_seed),
      .gen_x(gen_x), .gen_y(gen_y), .gen_z(gen_z), .gen_w(gen_w),
      .gen_valid(gen_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   // Generator model: gen_valid is sampled at the edge lat cycles after the pop edge.
   initial forever begin
      @(negedge clk);
      if (gen_pop_enable && cur_lat >= 0) begin
         repeat (cur_lat) @(negedge clk);
         gen_valid = 1'b1;
         {gen_x, gen_y, gen_z, gen_w} = cur_gen;
         @(negedge clk);
         gen_valid = 1'b0;
      end
   end

   // Protocol monitor over the whole run.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("err_without_valid", rsp_err && (rsp_valid == 0), 1'b0);
         chk("rsp_valid_onehot", $onehot0(rsp_valid), 1'b1);
         chk("rsp_valid_one_cycle", prev_rsp && (rsp_valid != 0), 1'b0);
         chk("grant_onehot", $onehot0(grant), 1'b1);
      end
      prev_rsp = (rsp_valid != 0);
   end

   task automatic run_txn(input vec_t v, input string tag);
      int t, lat, npop, nres;
      req_valid  = v.mask;
      req_reseed = v.reseed;
      for (int i = 0; i < 4; i++) req_seed[32*i +: 32] = v.exp_grant[i] ? v.seed : ~v.seed;
      cur_lat = v.lat;
      cur_gen = v.gen;
      t = 0;
      do begin @(negedge clk); t++; end while (grant == 0 && t < 20);
      chk({tag, " grant"}, grant, v.exp_grant);
      req_valid = req_valid & ~grant;
      lat = 0; npop = 0; nres = 0;
      do begin
         @(negedge clk);
         lat++;
         if (gen_pop_enable) npop++;
         if (gen_reseed_enable) begin
            nres++;
            chk({tag, " gen_seed"}, gen_seed, v.seed);
         end
      end while (rsp_valid == 0 && lat < 200);
      chk({tag, " rsp_valid"}, rsp_valid, v.exp_grant);
      chk({tag, " coords"}, {rsp_x, rsp_y, rsp_z, rsp_w}, v.exp_xyzw);
      chk({tag, " rsp_err"}, rsp_err, v.exp_err);
      chk({tag, " latency"}, lat, v.exp_lat);
      chk({tag, " pop_pulses"}, npop, v.reseed[0] | v.reseed[1] | v.reseed[2] | v.reseed[3] ? 0 : 1);
      chk({tag, " reseed_pulses"}, nres, v.reseed != 0 ? 1 : 0);
      chk({tag, " idle_at_rsp"}, busy, 1'b0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " grant"}, grant, 4'b0);
      chk({tag, " rsp_valid"}, rsp_valid, 4'b0);
      chk({tag, " rsp_err"}, rsp_err, 1'b0);
      chk({tag, " busy"}, busy, 1'b0);
      chk({tag, " pulses"}, {gen_pop_enable, gen_reseed_enable}, 2'b00);
      chk({tag, " gen_seed"}, gen_seed, 32'h0);
      chk({tag, " coords"}, {rsp_x, rsp_y, rsp_z, rsp_w}, 128'h0);
   endtask

   initial begin
      int t, seen;
      //           mask     reseed   seed          lat gen                                                    grant    expected coords                                        err lat
      vecs[0]  = '{4'b0001, 4'b0000, 32'h0,         8, {32'h40000000,32'h11111111,32'h22222222,32'h33333333}, 4'b0001, {32'h40000000,32'h11111111,32'h22222222,32'h33333333}, 0, 11};
      vecs[1]  = '{4'b0100, 4'b0100, 32'h0000002A, -1, 128'h0,                                                 4'b0100, 128'h0,                                                 0, 2};
      vecs[2]  = '{4'b1000, 4'b0000, 32'h0,         1, {32'hA,32'hB,32'hC,32'hD},                             4'b1000, {32'hA,32'hB,32'hC,32'hD},                             0, 4};
      vecs[3]  = '{4'b1111, 4'b0000, 32'h0,         2, {32'h1,32'h2,32'h3,32'h4},                             4'b0001, {32'h1,32'h2,32'h3,32'h4},                             0, 5};
      vecs[4]  = '{4'b1111, 4'b0000, 32'h0,         3, {32'h5,32'h6,32'h7,32'h8},                             4'b0010, {32'h5,32'h6,32'h7,32'h8},                             0, 6};
      vecs[5]  = '{4'b1111, 4'b0100, 32'hDEADBEEF, -1, 128'h0,                                                 4'b0100, 128'h0,                                                 0, 2};
      vecs[6]  = '{4'b1111, 4'b0000, 32'h0,         1, {32'h9,32'hA,32'hB,32'hC},                             4'b1000, {32'h9,32'hA,32'hB,32'hC},                             0, 4};
      vecs[7]  = '{4'b1111, 4'b0000, 32'h0,         5, {32'hFFFFFFFF,32'h0,32'hFFFFFFFF,32'h0},               4'b0001, {32'hFFFFFFFF,32'h0,32'hFFFFFFFF,32'h0},               0, 8};
      vecs[8]  = '{4'b1111, 4'b0000, 32'h0,         2, {32'h80000000,32'h1,32'h80000000,32'h1},               4'b0010, {32'h80000000,32'h1,32'h80000000,32'h1},               0, 5};
      vecs[9]  = '{4'b1111, 4'b0000, 32'h0,         4, {32'h12345678,32'h9ABCDEF0,32'h0F0F0F0F,32'hF0F0F0F0}, 4'b0100, {32'h12345678,32'h9ABCDEF0,32'h0F0F0F0F,32'hF0F0F0F0}, 0, 7};
      vecs[10] = '{4'b1111, 4'b0000, 32'h0,         1, {32'h55555555,32'hAAAAAAAA,32'h1,32'h2},               4'b1000, {32'h55555555,32'hAAAAAAAA,32'h1,32'h2},               0, 4};
      vecs[11] = '{4'b0010, 4'b0000, 32'h0,        63, {32'hC0000000,32'h1,32'h2,32'h3},                      4'b0010, {32'hC0000000,32'h1,32'h2,32'h3},                      0, 66};
      vecs[12] = '{4'b0100, 4'b0000, 32'h0,        -1, 128'h0,                                                 4'b0100, 128'h0,                                                 1, 66};
      vecs[13] = '{4'b0101, 4'b0000, 32'h0,         2, {32'h7,32'h6,32'h5,32'h4},                             4'b0001, {32'h7,32'h6,32'h5,32'h4},                             0, 5};
      vecs[14] = '{4'b0010, 4'b0000, 32'h0,        64, {32'h99,32'h98,32'h97,32'h96},                         4'b0010, 128'h0,                                                 1, 66};

      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 15; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

      // Requester 2 asserts while busy and withdraws before the FSM returns to IDLE.
      req_valid = 4'b1000; req_reseed = '0; cur_lat = 2;
      t = 0;
      do begin @(negedge clk); t++; end while (grant == 0 && t < 20);
      chk("skip grant", grant, 4'b1000);
      req_valid = 4'b0100;
      t = 0;
      do begin @(negedge clk); t++; end while (!gen_pop_enable && t < 20);
      req_valid = 4'b0000;
      t = 0; seen = 0;
      repeat (12) begin @(negedge clk); if (grant != 0) seen++; if (rsp_valid != 0) t++; end
      chk("skip rsp_count", t, 1);
      chk("skip no_grant", seen, 0);

      // Stray gen_valid in IDLE.
      gen_valid = 1'b1; {gen_x, gen_y, gen_z, gen_w} = {4{32'hBAD0BAD0}};
      @(negedge clk);
      gen_valid = 1'b0;
      seen = 0;
      repeat (6) begin @(negedge clk); if (rsp_valid != 0 || busy) seen++; end
      chk("stray_idle activity", seen, 0);

      // Reset while in WAIT.
      req_valid = 4'b0001; cur_lat = -1;
      t = 0;
      do begin @(negedge clk); t++; end while (!gen_pop_enable && t < 20);
      req_valid = 4'b0000;
      repeat (3) @(negedge clk);
      chk("wait busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      gen_valid = 1'b1;
      @(negedge clk);
      gen_valid = 1'b0;
      seen = 0;
      repeat (8) begin @(negedge clk); if (rsp_valid != 0 || busy) seen++; end
      chk("post_reset quiet", seen, 0);

      hv = '{4'b1010, 4'b0000, 32'h0, 3, {32'h31,32'h32,32'h33,32'h34}, 4'b0010,
             {32'h31,32'h32,32'h33,32'h34}, 0, 6};
      run_txn(hv, "post_reset_rr");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sphere3hopf_scheduler.md
SPHERE3HOPF_SCHEDULER -- requirements
Module: sphere3hopf_scheduler

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one sphere3hopf_32bit generator (2..8).
REQ-002 Parameter: TIMEOUT, default 64, maximum cycles waited for generator valid after a pop.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester request, held until granted.
REQ-006 req_reseed  input  NUM_REQ  per-requester op select: 1 = reseed, 0 = pop; sampled with grant.
REQ-007 req_seed  input  32*NUM_REQ  per-requester seed, slice i = bits [32i+31:32i].
REQ-008 grant  output  NUM_REQ  one-hot, one-cycle acceptance pulse.
REQ-009 rsp_valid  output  NUM_REQ  one-hot, one-cycle completion pulse to the owning requester.
REQ-010 rsp_x, rsp_y, rsp_z, rsp_w  output  32 each  shared coordinate bus, qualified by rsp_valid.
REQ-011 rsp_err  output  1  asserted with rsp_valid when the transaction timed out.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 gen_pop_enable, gen_reseed_enable  output  1 each  generator control pulses.
REQ-014 gen_seed  output  32  seed to generator.
REQ-015 gen_x, gen_y, gen_z, gen_w  input  32 each  generator coordinates.
REQ-016 gen_valid  input  1  generator output-valid flag.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one transaction outstanding at any time.
REQ-018 IDLE: if any req_valid bit set, select winner by round-robin, assert grant[winner] for one cycle, latch winner index, op and seed, go ISSUE; else remain.
REQ-019 Round-robin: search starts at index (last_winner+1) mod NUM_REQ; last_winner resets to NUM_REQ-1 so index 0 has first priority.
REQ-020 last_winner updates only on grant.
REQ-021 ISSUE, pop: gen_pop_enable high exactly one cycle, go WAIT, timeout counter cleared.
REQ-022 ISSUE, reseed: gen_reseed_enable high exactly one cycle with gen_seed = latched seed, go RESP with coordinates forced to 0 and err=0.
REQ-023 gen_seed holds the latched seed in all states; 0 after reset.
REQ-024 WAIT: gen_valid sampled only here; on gen_valid=1 latch gen_x..gen_w, go RESP.
REQ-025 WAIT: counter increments per cycle; if it reaches TIMEOUT without gen_valid, latch coordinates as 0, set err, go RESP.
REQ-026 gen_valid outside WAIT is ignored.
REQ-027 RESP: rsp_valid[winner]=1 for one cycle, rsp_x..rsp_w and rsp_err present latched values, go IDLE.
REQ-028 rsp_x..rsp_w hold last value between responses; rsp_err is 0 whenever rsp_valid is 0.
REQ-029 Minimum pop latency: grant cycle to rsp_valid = 3 + generator latency (IDLE, ISSUE, WAIT>=1, RESP); reseed = 2 cycles.
REQ-030 New requests, req_valid drops or req_reseed changes after grant do not affect the in-flight transaction.
REQ-031 A requester deasserting req_valid before grant is simply skipped.
REQ-032 Simultaneous gen_valid and timeout in same WAIT cycle: gen_valid wins, err=0.

Reset
REQ-033 rst_n low asynchronously forces IDLE, grant=0, rsp_valid=0, rsp_err=0, busy=0, gen_pop_enable=0, gen_reseed_enable=0, gen_seed=0, rsp_x..rsp_w=0, counter=0, last_winner=NUM_REQ-1.
REQ-034 Reset mid-transaction abandons it without any rsp_valid pulse; first grant after release follows REQ-019.

Verification
REQ-035 Single pop: req_valid=0001, generator valid 8 cycles after pop with x=0x40000000 -> grant[0] once, gen_pop_enable one pulse, rsp_valid[0] one cycle, rsp_x=0x40000000, rsp_err=0.
REQ-036 Fairness: req_valid=1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3; no rsp_valid to a non-owner.
REQ-037 Reseed: req 2 with req_reseed=1, seed=0x0000002A -> gen_reseed_enable one pulse with gen_seed=0x2A, rsp_valid[2] two cycles after grant, coordinates 0.
REQ-038 Timeout: TIMEOUT=64, gen_valid never asserted -> rsp_valid[owner] with rsp_err=1 exactly 64 WAIT cycles after ISSUE, coordinates 0, FSM back in IDLE.
REQ-039 Reset in WAIT: rst_n low during WAIT -> all outputs to reset values immediately, no rsp_valid; later gen_valid pulse ignored.
REQ-040 Boundary: gen_valid coincident with the 64th WAIT cycle -> rsp_err=0 with generator coordinates; stray gen_valid in IDLE produces no response.
